// File: rtl/morse_letter_scheduler.sv
// Queued Morse-code LED player: a small letter FIFO feeding a dot/dash/gap sequencer.
// Optional feature macro MORSE_HEX_EN adds the active-low HEX0 display of the letter in play.
module morse_letter_scheduler #(
  parameter int UNIT_CYCLES = 8388608,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               CLOCK_50,
  input  logic                               RESET,
  input  logic                               letter_valid,
  input  logic [2:0]                         letter,
  output logic                               letter_ready,
  output logic                               led,
  output logic                               busy,
  output logic [2:0]                         cur_letter,
  output logic                               letter_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
`ifdef MORSE_HEX_EN
  ,
  output logic [6:0]                         HEX0
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TW    = $clog2(3 * UNIT_CYCLES) + 1;
  localparam logic [TW-1:0]    UNIT_M1 = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0]    TRI_M1  = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2,
    S_LGAP = 2'd3
  } state_t;

  // Symbol ROM: {element count, pattern left-aligned MSB first, 1 = dash}
  function automatic logic [6:0] symbol_rom(input logic [2:0] code);
    logic [6:0] v;
    case (code)
      3'd0:    v = {3'd2, 4'b0100};
      3'd1:    v = {3'd4, 4'b1000};
      3'd2:    v = {3'd4, 4'b1010};
      3'd3:    v = {3'd3, 4'b1000};
      3'd4:    v = {3'd1, 4'b0000};
      3'd5:    v = {3'd4, 4'b0010};
      3'd6:    v = {3'd3, 4'b1100};
      3'd7:    v = {3'd4, 4'b0000};
      default: v = {3'd1, 4'b0000};
    endcase
    return v;
  endfunction

`ifdef MORSE_HEX_EN
  function automatic logic [6:0] hex_seg(input logic [2:0] code);
    logic [6:0] s;
    case (code)
      3'd0:    s = 7'b0001000;
      3'd1:    s = 7'b0000000;
      3'd2:    s = 7'b1000110;
      3'd3:    s = 7'b1000000;
      3'd4:    s = 7'b0000110;
      3'd5:    s = 7'b0001110;
      3'd6:    s = 7'b1000010;
      3'd7:    s = 7'b0001001;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction
`endif

  state_t             r_state;
  state_t             w_next;
  logic [TW-1:0]      r_tcnt;
  logic [3:0]         r_pat;
  logic [2:0]         r_len;
  logic [2:0]         r_cur;
  logic               r_led;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [2:0]         r_mem [FIFO_DEPTH];
  logic [2:0]         w_head;
  logic [6:0]         w_sym;
  logic [2:0]         w_cur_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_done;
  logic               w_shift;
  logic               w_leave;

  assign w_push    = letter_valid && (r_count != FULL_CNT);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_sym     = symbol_rom(w_head);
  assign w_leave   = (w_next != r_state);
  assign w_cur_nxt = w_pop ? w_head : r_cur;

  // Next-state logic; pops are decided on the pre-push occupancy
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_done  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = S_ON;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ON: begin
        if (r_tcnt == (r_pat[3] ? TRI_M1 : UNIT_M1)) begin
          if (r_len > 3'd1) begin
            w_shift = 1'b1;
            w_next  = S_GAP;
          end else begin
            w_done = 1'b1;
            w_next = S_LGAP;
          end
        end else begin
          w_next = S_ON;
        end
      end
      S_GAP: begin
        if (r_tcnt == UNIT_M1) begin
          w_next = S_ON;
        end else begin
          w_next = S_GAP;
        end
      end
      S_LGAP: begin
        if (r_tcnt == TRI_M1) begin
          if (r_count != '0) begin
            w_pop  = 1'b1;
            w_next = S_ON;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_next = S_LGAP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Occupancy update for simultaneous push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // FIFO storage
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= letter;
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Element shift register, unit timer and current letter
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_tcnt <= '0;
      r_pat  <= 4'd0;
      r_len  <= 3'd0;
      r_cur  <= 3'd0;
    end else begin
      r_tcnt <= (w_leave || r_state == S_IDLE) ? '0 : r_tcnt + TW'(1);
      if (w_pop) begin
        r_len <= w_sym[6:4];
        r_pat <= w_sym[3:0];
      end else if (w_shift) begin
        r_len <= r_len - 3'd1;
        r_pat <= {r_pat[2:0], 1'b0};
      end
      r_cur <= w_cur_nxt;
    end
  end

  // Registered outputs follow the next state so they align with it
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_led  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_led  <= (w_next == S_ON);
      r_busy <= (w_next != S_IDLE);
      r_done <= w_done;
    end
  end

`ifdef MORSE_HEX_EN
  logic [6:0] r_hex;

  // Display shows the letter in play, blank while idle
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_hex <= 7'b1111111;
    end else begin
      r_hex <= (w_next != S_IDLE) ? hex_seg(w_cur_nxt) : 7'b1111111;
    end
  end

  assign HEX0 = r_hex;
`endif

  assign letter_ready = r_ready;
  assign led          = r_led;
  assign busy         = r_busy;
  assign cur_letter   = r_cur;
  assign letter_done  = r_done;
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_morse_letter_scheduler.sv
// Bench for morse_letter_scheduler: a cycle-plan model built from the Morse strings,
// checked every cycle, plus hand-computed directed expectations.
module tb_morse_letter_scheduler;
  localparam int U = 2;
  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       letter_valid = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       letter_ready, led, busy, letter_done;
  logic [2:0] cur_letter;
  logic [2:0] fifo_count;
`ifdef MORSE_HEX_EN
  logic [6:0] hex0;
`endif

  int vectors = 0;
  int miscompares = 0;

  morse_letter_scheduler #(.UNIT_CYCLES(U), .FIFO_DEPTH(D)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .letter_valid(letter_valid), .letter(letter),
    .letter_ready(letter_ready), .led(led), .busy(busy), .cur_letter(cur_letter),
    .letter_done(letter_done), .fifo_count(fifo_count)
`ifdef MORSE_HEX_EN
    , .HEX0(hex0)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Model: each popped letter expands into a list of per-cycle (led, done) steps
  typedef struct packed { logic led; logic done; } step_t;
  logic [2:0] mq[$];
  step_t      plan[$];
  logic [2:0] m_cur = 3'd0;
  bit         m_acc;

  function automatic string sym(input logic [2:0] c);
    case (c)
      3'd0: return ".-";
      3'd1: return "-...";
      3'd2: return "-.-.";
      3'd3: return "-..";
      3'd4: return ".";
      3'd5: return "..-.";
      3'd6: return "--.";
      default: return "....";
    endcase
  endfunction

  task automatic expand(input logic [2:0] c);
    string s;
    int n;
    s = sym(c);
    for (int i = 0; i < s.len(); i++) begin
      n = (s[i] == "-") ? 3 * U : U;
      for (int k = 0; k < n; k++) plan.push_back('{led: 1'b1, done: 1'b0});
      if (i != s.len() - 1)
        for (int k = 0; k < U; k++) plan.push_back('{led: 1'b0, done: 1'b0});
    end
    for (int k = 0; k < 3 * U; k++) plan.push_back('{led: 1'b0, done: (k == 0)});
  endtask

  always @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mq.delete();
      plan.delete();
      m_cur = 3'd0;
    end else begin
      m_acc = letter_valid && (mq.size() < D);
      if (plan.size() > 0) void'(plan.pop_front());
      if (plan.size() == 0 && mq.size() > 0) begin
        m_cur = mq.pop_front();
        expand(m_cur);
      end
      if (m_acc) mq.push_back(letter);
    end
  end

  logic       e_led, e_busy, e_done, e_ready;
  logic [2:0] e_count;

  always @(negedge CLOCK_50) begin
    if (!RESET) begin
      e_busy  = (plan.size() != 0);
      e_led   = e_busy ? plan[0].led : 1'b0;
      e_done  = e_busy ? plan[0].done : 1'b0;
      e_count = 3'(mq.size());
      e_ready = (mq.size() < D);
      vectors++;
      if (led !== e_led || busy !== e_busy || letter_done !== e_done ||
          fifo_count !== e_count || letter_ready !== e_ready || cur_letter !== m_cur) begin
        miscompares++;
        $display("FAIL cycle t=%0t led=%b/%b busy=%b/%b done=%b/%b cnt=%0d/%0d rdy=%b/%b cur=%0d/%0d (got/want)",
                 $time, led, e_led, busy, e_busy, letter_done, e_done, fifo_count, e_count,
                 letter_ready, e_ready, cur_letter, m_cur);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] c);
    letter_valid = 1'b1;
    letter = c;
    @(negedge CLOCK_50);
    letter_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 3'd0) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("idle_within_budget", {31'd0, (busy || fifo_count != 3'd0)}, 32'd0);
  endtask

  logic [15:0] a_bits;
  int falls, dark, dones;
  logic prev, rose, rdy;
  int k;
  logic [2:0] codes [6] = '{3'd1, 3'd7, 3'd4, 3'd6, 3'd3, 3'd5};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", letter_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_done", letter_done, 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // E: one dot then a 3-unit letter gap
    push(3'd4);
    chk("E_prepop_led", led, 0);
    chk("E_prepop_count", fifo_count, 1);
    @(negedge CLOCK_50); chk("E_lit1", led, 1); chk("E_busy", busy, 1);
    @(negedge CLOCK_50); chk("E_lit2", led, 1);
    @(negedge CLOCK_50); chk("E_fall", led, 0); chk("E_done", letter_done, 1);
    repeat (5) @(negedge CLOCK_50); chk("E_lgap_busy", busy, 1);
    @(negedge CLOCK_50); chk("E_idle", busy, 0); chk("E_done_off", letter_done, 0);
    repeat (10) @(negedge CLOCK_50);

    // A: dot, gap, dash, letter gap
    push(3'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50);
      a_bits[15-i] = led;
`ifdef MORSE_HEX_EN
      if (i == 0) chk("A_hex", hex0, 7'b0001000);
`endif
    end
    chk("A_pattern", a_bits, 16'b1100111111000000);
    chk("A_cur", cur_letter, 0);
    wait_idle(50);

    // H then B back to back
    falls = 0; dark = 0; dones = 0; prev = 1'b0; rose = 1'b0;
    letter_valid = 1'b1; letter = 3'd7;
    @(negedge CLOCK_50);
    letter = 3'd1;
    @(negedge CLOCK_50);
    letter_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (prev && !led) falls++;
      if (falls == 4 && !rose) begin
        if (led) rose = 1'b1;
        else dark++;
      end
      if (letter_done) dones++;
      prev = led;
      @(negedge CLOCK_50);
    end
    chk("HB_dark_gap", dark, 6);
    chk("HB_dones", dones, 2);
    chk("HB_idle", busy, 0);

    // Hold valid across six codes; queue fills and back-pressures
    k = 0;
    letter_valid = 1'b1;
    letter = codes[0];
    for (int cyc = 0; cyc < 400 && k < 6; cyc++) begin
      rdy = letter_ready;
      @(negedge CLOCK_50);
      if (rdy) begin
        k++;
        if (k == 5) begin
          chk("full_ready", letter_ready, 0);
          chk("full_count", fifo_count, 4);
        end
        if (k < 6) letter = codes[k];
      end
    end
    letter_valid = 1'b0;
    chk("hold_accepted", k, 6);
    wait_idle(600);
    repeat (4) @(negedge CLOCK_50);

    // Reset in the second cycle of C's first dash, with G queued behind it
    push(3'd2);
    push(3'd6);
    chk("C_dash_start", led, 1);
    chk("C_queued", fifo_count, 1);
    @(posedge CLOCK_50);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_done", letter_done, 0);
    chk("mid_rst_ready", letter_ready, 1);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    chk("post_rst_quiet", {31'd0, busy | led}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/morse_letter_scheduler.md
# morse_letter_scheduler

Queued Morse-code player for the board LED. Requesters push 3-bit letter codes (A–H) through a valid/ready port into a small FIFO. An FSM plays each letter on a single LED line with standard Morse unit timing: dot, dash, intra-letter gap and inter-letter gap. It sits between the switch/key front end and LEDR, and owns all Morse sequencing and timing.

## Interface
Parameters:
- UNIT_CYCLES, 8388608 — clock cycles per Morse time unit; must be ≥ 1.
- FIFO_DEPTH, 4 — letter queue entries; power of two, ≥ 2.

Ports:
- CLOCK_50  in  1  — single clock; all state on its rising edge.
- RESET  in  1  — asynchronous, active-high reset.
- letter_valid  in  1  — requester presents a letter.
- letter  in  3  — 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H.
- letter_ready  out  1  — FIFO not full; a push occurs when valid && ready at a clock edge.
- led  out  1  — Morse output; 1 = lit.
- busy  out  1  — FSM not in IDLE.
- cur_letter  out  3  — code of the letter being played; holds its last value when idle.
- letter_done  out  1  — one-cycle pulse when the last element of a letter ends.
- fifo_count  out  clog2(FIFO_DEPTH+1)  — queued entries, excluding the letter in play.

## Operation
- Symbol ROM (MSB first, dot=., dash=-):
  - A .-
  - B -...
  - C -.-.
  - D -..
  - E .
  - F ..-.
  - G --.
  - H ....
- Element lengths:
  - dot = 1 unit lit.
  - dash = 3 units lit.
  - gap between elements = 1 unit dark.
  - gap after a letter = 3 units dark.
  - 1 unit = UNIT_CYCLES cycles.
- FSM states: IDLE, ON, GAP, LGAP.
  - IDLE: if fifo_count > 0, pop the head, load its pattern and length into the shift register, set cur_letter, go to ON.
  - ON: led=1 for 1 or 3 units. When it expires:
    - if elements remain, shift and go to GAP;
    - otherwise pulse letter_done and go to LGAP.
  - GAP: led=0 for 1 unit, then go to ON.
  - LGAP: led=0 for 3 units. When it expires:
    - if fifo_count > 0, pop directly into ON (no IDLE cycle);
    - otherwise go to IDLE.
- The unit counter clears on every state entry.
- FIFO behaviour:
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, letter_ready=0 and pushes are ignored.
  - When empty, no pop occurs; a letter pushed at edge t is first seen by IDLE at edge t+1.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Letter codes are 3 bits, so every code is valid; there is no error path.

## Timing
- Reset values: led=0, busy=0, letter_done=0, cur_letter=0, fifo_count=0, letter_ready=1, state=IDLE, pointers=0.
- Latency from push to light: push at edge t into an empty idle block, pop at edge t+1, led=1 from edge t+1 (led is registered).
- led is high for exactly UNIT_CYCLES or 3×UNIT_CYCLES cycles per element.
- Dark time between back-to-back queued letters: exactly 3×UNIT_CYCLES cycles, measured from led fall to next led rise.
- letter_done is asserted in the same cycle that led falls on the last element.
- busy falls on the edge where LGAP exits to IDLE.
- RESET asserted mid-letter: all outputs go to their reset values immediately (asynchronously) and the queue is discarded. The first edge after deassertion behaves as IDLE with an empty FIFO.
- letter_valid and letter may change freely; they are sampled only at clock edges.

## Configuration
- MORSE_HEX_EN defined: adds output HEX0[6:0] (active-low 7-segment) showing cur_letter while busy, and all-ones (blank) when idle. Segment codes:
  - A 0001000
  - B 0000000
  - C 1000110
  - D 1000000
  - E 0000110
  - F 0001110
  - G 1000010
  - H 0001001
- MORSE_HEX_EN undefined: HEX0 port and its decode logic are absent; all other behaviour is identical.

## Test plan
All scenarios use UNIT_CYCLES=2 and FIFO_DEPTH=4.
- Reset: pulse RESET, hold 3 cycles -> led=0, busy=0, letter_ready=1, fifo_count=0, letter_done=0.
- Push E (4) at edge t -> led=1 for edges t+1..t+2 (2 cycles), letter_done pulses at t+3, busy=0 after 6 dark cycles, no further activity.
- Push A (0) -> led pattern high 2, low 2, high 6, then low 6; cur_letter=0; HEX0=0001000 when MORSE_HEX_EN is defined.
- Push H then B on consecutive cycles -> exactly 6 dark cycles between the fall of H's 4th dot and the rise of B's dash; two letter_done pulses.
- Hold letter_valid with 6 distinct codes -> codes 1–5 accepted; letter_ready=0 with fifo_count=4; 6th code accepted on the cycle after letter 2 is popped; letters play in push order.
- Assert RESET during the 2nd cycle of C's first dash -> led=0 and busy=0 immediately, fifo_count=0, no letter_done; after release, no activity until a new push.
